ysyx_22040386_lsu: RTL and testbench

Parametrised load/store unit that replaces the combinational memory-access path of the MEM stage with a multi-cycle request/grant/response bus interface.
- Latches one access from the MEM stage and generates the aligned bus address, byte mask and lane-shifted write data.
- Extracts and sign- or zero-extends load data.
- Detects misaligned or illegal accesses and grant timeouts.
- Stalls the pipeline until the access completes.

---
 rtl/ysyx_22040386_lsu_pkg.sv | 43 ++++
 rtl/ysyx_22040386_lsu_if.sv | 34 +++
 rtl/ysyx_22040386_lsu_align.sv | 56 +++++
 rtl/ysyx_22040386_lsu.sv | 161 ++++++++++++++++
 tb/tb_ysyx_22040386_lsu.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040386_lsu_pkg.sv
// Shared definitions for the load/store unit and its alignment helper.
// Contents:
//   SZ_B/SZ_H/SZ_W/SZ_D  encodings of i_lsu_size[1:0]
//   SZ_UNSIGNED           bit index of the unsigned-load flag in i_lsu_size
//   lsu_state_e           access FSM states
//   base_mask()           byte mask of an access at lane offset 0
//   misaligned()          natural-alignment check on the low address bits
package ysyx_22040386_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int SZ_UNSIGNED = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  // Eight bits wide so the same helper serves 32- and 64-bit datapaths;
  // callers keep the low MW bits.
  function automatic logic [7:0] base_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    base_mask = 8'h01;
      SZ_H:    base_mask = 8'h03;
      SZ_W:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = a[0];
      SZ_W:    misaligned = |a[1:0];
      default: misaligned = |a;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040386_lsu_if.sv
// Request/grant/response memory bus between the LSU (master) and memory (slave).
// Signals:
//   o_bus_req/i_bus_gnt        request handshake; fields stable until grant
//   o_bus_we, o_bus_addr       write enable, MW-aligned address
//   o_bus_wdata, o_bus_wmask   lane-shifted store data and byte mask
//   i_bus_rvalid, i_bus_rdata  response strobe and raw read data
//   i_bus_err                  bus error, meaningful with i_bus_rvalid
interface ysyx_22040386_lsu_if #(
  parameter int XLEN = 64,
  parameter int AW   = 64
);
  localparam int MW = XLEN / 8;

  logic            o_bus_req;
  logic            i_bus_gnt;
  logic            o_bus_we;
  logic [AW-1:0]   o_bus_addr;
  logic [XLEN-1:0] o_bus_wdata;
  logic [MW-1:0]   o_bus_wmask;
  logic            i_bus_rvalid;
  logic [XLEN-1:0] i_bus_rdata;
  logic            i_bus_err;

  modport master (
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wmask,
    input  i_bus_gnt, i_bus_rvalid, i_bus_rdata, i_bus_err
  );

  modport slave (
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wmask,
    output i_bus_gnt, i_bus_rvalid, i_bus_rdata, i_bus_err
  );

endinterface

// File: rtl/ysyx_22040386_lsu_align.sv
// Combinational lane alignment shared by the LSU and, later, the data cache.
// Ports:
//   off        byte offset of the access inside one XLEN word
//   size       [1:0] access size, [2] unsigned-load flag
//   wdata      right-justified store data
//   rdata_raw  raw bus word
//   wmask      byte mask shifted to the access lanes
//   wdata_sh   store data shifted to the access lanes
//   rdata_ext  load data shifted down, truncated and sign/zero-extended
module ysyx_22040386_lsu_align
  import ysyx_22040386_lsu_pkg::*;
#(
  parameter  int XLEN = 64,
  localparam int MW   = XLEN / 8,
  localparam int OW   = $clog2(MW),
  localparam int IW   = $clog2(XLEN)
) (
  input  logic [OW-1:0]   off,
  input  logic [2:0]      size,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata_raw,
  output logic [MW-1:0]   wmask,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]      bm;
  logic [MW-1:0]   mask_base;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] lane_keep;
  logic [IW-1:0]   top_idx;
  logic            sign;

  // The byte mask at offset 0 doubles as the bit-keep mask for extension:
  // kept bytes pass through, the rest are filled with the sign bit.
  always_comb begin
    bm        = base_mask(size[1:0]);
    mask_base = bm[MW-1:0];
    wmask     = mask_base << off;
    wdata_sh  = wdata << {off, 3'b000};
    shifted   = rdata_raw >> {off, 3'b000};
    lane_keep = '0;
    for (int i = 0; i < MW; i++) begin
      lane_keep[8*i +: 8] = {8{mask_base[i]}};
    end
    case (size[1:0])
      SZ_B:    top_idx = IW'(7);
      SZ_H:    top_idx = IW'(15);
      SZ_W:    top_idx = IW'(31);
      default: top_idx = IW'(XLEN - 1);
    endcase
    sign      = shifted[top_idx] & ~size[SZ_UNSIGNED];
    rdata_ext = (shifted & lane_keep) | ({XLEN{sign}} & ~lane_keep);
  end

endmodule

// File: rtl/ysyx_22040386_lsu.sv
// Multi-cycle load/store unit for the MEM stage.
// Latches one access, screens it for illegal/misaligned forms, then runs a
// request/grant/response transaction on the bus interface and returns the
// extended load data with a one-cycle done pulse.
// Ports:
//   i_lsu_clk, i_lsu_rst_n     clock, asynchronous active-low reset
//   i_lsu_valid/read/write     access request from MEM, held until done
//   i_lsu_size/addr/wdata      access size (+unsigned flag), address, store data
//   o_lsu_ready                access accepted this cycle
//   o_lsu_done/rdata/err       completion pulse with load data and error
//   o_lsu_stall                pipeline stall
//   bus                        memory bus (master side)
module ysyx_22040386_lsu
  import ysyx_22040386_lsu_pkg::*;
#(
  parameter  int XLEN        = 64,
  parameter  int AW          = 64,
  parameter  int BUS_TIMEOUT = 255,
  localparam int MW          = XLEN / 8
) (
  input  logic            i_lsu_clk,
  input  logic            i_lsu_rst_n,
  input  logic            i_lsu_valid,
  input  logic            i_lsu_read,
  input  logic            i_lsu_write,
  input  logic [2:0]      i_lsu_size,
  input  logic [AW-1:0]   i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wdata,
  output logic            o_lsu_ready,
  output logic            o_lsu_done,
  output logic [XLEN-1:0] o_lsu_rdata,
  output logic            o_lsu_err,
  output logic            o_lsu_stall,
  ysyx_22040386_lsu_if.master bus
);

  localparam int OW = $clog2(MW);
  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  lsu_state_e      state, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [AW-1:0]   addr_q;
  logic [2:0]      size_q;
  logic            read_q, write_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q, rdata_n;
  logic            err_q, err_n;

  logic            accept, in_req, illegal;
  logic [MW-1:0]   al_wmask;
  logic [XLEN-1:0] al_wdata, al_rdata;

  assign accept  = (state == ST_IDLE) && i_lsu_valid;
  assign in_req  = (state == ST_REQ);
  assign illegal = misaligned(i_lsu_size[1:0], i_lsu_addr[2:0]) ||
                   ((XLEN == 32) && (i_lsu_size[1:0] == SZ_D));

  ysyx_22040386_lsu_align #(.XLEN(XLEN)) u_align (
    .off       (addr_q[OW-1:0]),
    .size      (size_q),
    .wdata     (wdata_q),
    .rdata_raw (bus.i_bus_rdata),
    .wmask     (al_wmask),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata)
  );

  // Next-state logic. Result registers are written on every entry into DONE
  // so rdata/err are settled for the whole done cycle. A NOP is screened
  // before alignment, so a NOP with an odd address completes cleanly.
  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    case (state)
      ST_IDLE: begin
        if (i_lsu_valid) begin
          rdata_n = '0;
          err_n   = 1'b0;
          cnt_n   = '0;
          if (i_lsu_read && i_lsu_write) begin
            state_n = ST_DONE;
            err_n   = 1'b1;
          end else if (!i_lsu_read && !i_lsu_write) begin
            state_n = ST_DONE;
          end else if (illegal) begin
            state_n = ST_DONE;
            err_n   = 1'b1;
          end else begin
            state_n = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.i_bus_gnt) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end else if (cnt_q == CW'(BUS_TIMEOUT - 1)) begin
          state_n = ST_DONE;
          err_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (bus.i_bus_rvalid) begin
          state_n = ST_DONE;
          err_n   = bus.i_bus_err;
          rdata_n = read_q ? al_rdata : '0;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State and datapath registers; the access fields are captured only on
  // acceptance so the bus fields stay stable while waiting for grant.
  always_ff @(posedge i_lsu_clk or negedge i_lsu_rst_n) begin
    if (!i_lsu_rst_n) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt_q   <= cnt_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
      if (accept) begin
        addr_q  <= i_lsu_addr;
        size_q  <= i_lsu_size;
        read_q  <= i_lsu_read;
        write_q <= i_lsu_write;
        wdata_q <= i_lsu_wdata;
      end
    end
  end

  // Bus fields are forced to zero outside REQ so the bus is quiet at reset
  // and between transactions.
  assign bus.o_bus_req   = in_req;
  assign bus.o_bus_we    = in_req & write_q;
  assign bus.o_bus_addr  = in_req ? {addr_q[AW-1:OW], {OW{1'b0}}} : '0;
  assign bus.o_bus_wdata = in_req ? al_wdata : '0;
  assign bus.o_bus_wmask = in_req ? al_wmask : '0;

  assign o_lsu_ready = accept;
  assign o_lsu_done  = (state == ST_DONE);
  assign o_lsu_rdata = rdata_q;
  assign o_lsu_err   = err_q;
  assign o_lsu_stall = i_lsu_valid & ~o_lsu_done;

endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Scoreboard bench for ysyx_22040386_lsu: the stimulus process pushes the
// expected bus transaction and completion into queues; a bus slave process
// answers and checks requests, and a monitor checks every completion.
module tb_ysyx_22040386_lsu;

  localparam int XLEN        = 64;
  localparam int AW          = 64;
  localparam int BUS_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, lsu_read, lsu_write;
  logic [2:0]  lsu_size;
  logic [63:0] lsu_addr, lsu_wdata;
  logic        o_lsu_ready, o_lsu_done, o_lsu_err, o_lsu_stall;
  logic [63:0] o_lsu_rdata;

  ysyx_22040386_lsu_if #(.XLEN(XLEN), .AW(AW)) bus_if ();

  ysyx_22040386_lsu #(.XLEN(XLEN), .AW(AW), .BUS_TIMEOUT(BUS_TIMEOUT)) dut (
    .i_lsu_clk   (clk),
    .i_lsu_rst_n (rst_n),
    .i_lsu_valid (lsu_valid),
    .i_lsu_read  (lsu_read),
    .i_lsu_write (lsu_write),
    .i_lsu_size  (lsu_size),
    .i_lsu_addr  (lsu_addr),
    .i_lsu_wdata (lsu_wdata),
    .o_lsu_ready (o_lsu_ready),
    .o_lsu_done  (o_lsu_done),
    .o_lsu_rdata (o_lsu_rdata),
    .o_lsu_err   (o_lsu_err),
    .o_lsu_stall (o_lsu_stall),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          g;
    int          r;
    logic [63:0] rdata;
    logic        err;
    bit          tmo;
  } bus_plan_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    bit          chk_rdata;
  } resp_t;

  bus_plan_t plan_q[$];
  resp_t     exp_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        stray_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-level view of an access.
  function automatic void model(input bit rd, input bit wr, input logic [2:0] sz,
                                input logic [63:0] a, input logic [63:0] wd,
                                input logic [63:0] brd, input bit berr, input bit tmo,
                                output bit on_bus, output logic [63:0] erd, output bit eerr,
                                output bit chk, output logic [7:0] em, output logic [63:0] ewd);
    int n   = 1 << sz[1:0];
    int off = int'(a[2:0]);
    on_bus = 0; erd = '0; eerr = 0; chk = 0; em = '0; ewd = '0;
    if (rd && wr) eerr = 1;
    else if (!rd && !wr) chk = 1;
    else if ((off % n) != 0) eerr = 1;
    else begin
      on_bus = 1;
      for (int k = 0; k < n; k++) em[off+k] = 1'b1;
      ewd = wd << (8 * off);
      if (tmo) eerr = 1;
      else begin
        eerr = berr;
        chk  = rd && !berr;
        for (int k = 0; k < n; k++) erd[8*k +: 8] = brd[8*(off+k) +: 8];
        if (!sz[2] && n < 8 && erd[8*n-1])
          for (int k = n; k < 8; k++) erd[8*k +: 8] = 8'hFF;
      end
    end
  endfunction

  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] sz,
                               input logic [63:0] a, input logic [63:0] wd,
                               input int g, input int r, input logic [63:0] brd,
                               input bit berr, input bit tmo);
    bit on_bus, eerr, chk, acc, seen;
    logic [63:0] erd, ewd;
    logic [7:0] em;
    int elat, lat;
    bus_plan_t p;
    resp_t e;
    model(rd, wr, sz, a, wd, brd, berr, tmo, on_bus, erd, eerr, chk, em, ewd);
    if (on_bus) begin
      p.addr = {a[63:3], 3'b000}; p.we = wr; p.wdata = ewd; p.wmask = em;
      p.g = g; p.r = r; p.rdata = brd; p.err = berr; p.tmo = tmo;
      plan_q.push_back(p);
      elat = tmo ? 1 + BUS_TIMEOUT : 3 + g + r;
    end else begin
      elat = 1;
    end
    e.rdata = erd; e.err = eerr; e.chk_rdata = chk;
    exp_q.push_back(e);
    @(negedge clk);
    lsu_valid = 1; lsu_read = rd; lsu_write = wr; lsu_size = sz;
    lsu_addr = a; lsu_wdata = wd;
    acc = 0;
    for (int i = 0; i < 5 && !acc; i++) begin
      #1;
      if (o_lsu_ready === 1'b1) acc = 1;
      else @(negedge clk);
    end
    checkOutput("accept", acc, 1);
    lat = 0; seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (o_lsu_done === 1'b1) begin seen = 1; lat = i; end
    end
    checkOutput("latency", lat, elat);
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    lsu_valid = 0; lsu_read = 0; lsu_write = 0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Bus slave: grants after plan.g request cycles, answers plan.r cycles
  // after the grant, and throws in stray responses where they must be ignored.
  initial begin : bus_slave
    bus_plan_t cur;
    int cnt, rcnt, smode, strays_done;
    smode = 0; cnt = 0; rcnt = 0; strays_done = 0;
    bus_if.i_bus_gnt = 0; bus_if.i_bus_rvalid = 0; bus_if.i_bus_rdata = '0; bus_if.i_bus_err = 0;
    forever begin
      @(negedge clk);
      bus_if.i_bus_gnt = 0; bus_if.i_bus_rvalid = 0; bus_if.i_bus_err = 0;
      bus_if.i_bus_rdata = {$urandom, $urandom};
      if (!rst_n) begin
        smode = 0;
        continue;
      end
      if (smode == 0) begin
        if (bus_if.o_bus_req) begin
          if (plan_q.size() == 0) checkOutput("unexpected_req", bus_if.o_bus_req, 0);
          else begin cur = plan_q.pop_front(); cnt = 0; smode = 1; end
        end else if (strays_done != stray_cnt) begin
          strays_done++;
          bus_if.i_bus_rvalid = 1; bus_if.i_bus_err = 1;
        end else if ($urandom_range(3) == 0) begin
          bus_if.i_bus_rvalid = 1; bus_if.i_bus_err = 1;
        end
      end
      if (smode == 1) begin
        if (bus_if.o_bus_req) begin
          checkOutput("bus_addr", bus_if.o_bus_addr, cur.addr);
          checkOutput("bus_we", bus_if.o_bus_we, cur.we);
          checkOutput("bus_wmask", bus_if.o_bus_wmask, cur.wmask);
          if (cur.we) checkOutput("bus_wdata", bus_if.o_bus_wdata, cur.wdata);
          if (!cur.tmo && cnt == cur.g) begin
            bus_if.i_bus_gnt = 1;
            if ($urandom_range(1) == 1) begin bus_if.i_bus_rvalid = 1; bus_if.i_bus_err = 1; end
            smode = 2; rcnt = 0;
          end else cnt++;
        end else begin
          if (cur.tmo) checkOutput("timeout_req_cycles", cnt, BUS_TIMEOUT);
          else checkOutput("req_held", bus_if.o_bus_req, 1);
          smode = 0;
        end
      end else if (smode == 2) begin
        checkOutput("req_low_in_wait", bus_if.o_bus_req, 0);
        if (rcnt == cur.r) begin
          bus_if.i_bus_rvalid = 1; bus_if.i_bus_rdata = cur.rdata; bus_if.i_bus_err = cur.err;
          smode = 0;
        end else rcnt++;
      end
    end
  end

  // Monitor: stall relation every cycle, and each done pulse against the
  // head of the expected-response queue.
  initial begin : monitor
    bit prev_done;
    resp_t e;
    prev_done = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin prev_done = 0; continue; end
      checkOutput("stall", o_lsu_stall, lsu_valid & ~o_lsu_done);
      if (o_lsu_done) begin
        checkOutput("done_one_cycle", prev_done, 0);
        if (exp_q.size() == 0) checkOutput("unexpected_done", o_lsu_done, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("lsu_err", o_lsu_err, e.err);
          if (e.chk_rdata) checkOutput("lsu_rdata", o_lsu_rdata, e.rdata);
        end
      end
      prev_done = o_lsu_done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bus_plan_t p;
    logic [2:0]  sz;
    logic [63:0] a;
    int op, n;
    rst_n = 1; lsu_valid = 0; lsu_read = 0; lsu_write = 0;
    lsu_size = 0; lsu_addr = '0; lsu_wdata = '0;
    #1 rst_n = 0;
    @(negedge clk); @(negedge clk); #1;
    $display("[TB] checking reset state");
    checkOutput("rst_ready", o_lsu_ready, 0);
    checkOutput("rst_done", o_lsu_done, 0);
    checkOutput("rst_err", o_lsu_err, 0);
    checkOutput("rst_rdata", o_lsu_rdata, 0);
    checkOutput("rst_req", bus_if.o_bus_req, 0);
    checkOutput("rst_we", bus_if.o_bus_we, 0);
    checkOutput("rst_addr", bus_if.o_bus_addr, 0);
    checkOutput("rst_wdata", bus_if.o_bus_wdata, 0);
    checkOutput("rst_wmask", bus_if.o_bus_wmask, 0);
    @(negedge clk); rst_n = 1;

    $display("[TB] directed accesses");
    applyStimulus(1, 0, 3'b000, 64'h8000_0003, 64'h0, 0, 0, 64'h0000_0000_8000_0000, 0, 0);
    applyStimulus(1, 0, 3'b100, 64'h8000_0003, 64'h0, 1, 1, 64'h0000_0000_8000_0000, 0, 0);
    applyStimulus(0, 1, 3'b001, 64'h8000_0006, 64'hBEEF, 0, 0, 64'h0, 0, 0);
    applyStimulus(1, 0, 3'b010, 64'h8000_0002, 64'h0, 0, 0, 64'h0, 0, 0);
    applyStimulus(1, 0, 3'b011, 64'h8000_0010, 64'h0, 0, 0, 64'h0, 0, 1);
    applyStimulus(1, 0, 3'b011, 64'h8000_0020, 64'h0, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
    applyStimulus(0, 1, 3'b011, 64'h8000_0028, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 64'h0, 0, 0);
    applyStimulus(1, 1, 3'b010, 64'h8000_0000, 64'h0, 0, 0, 64'h0, 0, 0);
    applyStimulus(0, 0, 3'b001, 64'h8000_0001, 64'h0, 0, 0, 64'h0, 0, 0);
    applyStimulus(1, 0, 3'b001, 64'h8000_0004, 64'h0, 0, 2, 64'h0000_8123_0000_0000, 1, 0);
    idleCycles(2);

    $display("[TB] reset during WAIT");
    p.addr = 64'h8000_0040; p.we = 0; p.wdata = '0; p.wmask = 8'hFF;
    p.g = 0; p.r = 20; p.rdata = '0; p.err = 0; p.tmo = 0;
    plan_q.push_back(p);
    @(negedge clk);
    lsu_valid = 1; lsu_read = 1; lsu_write = 0; lsu_size = 3'b011; lsu_addr = 64'h8000_0040;
    #1 checkOutput("rw_ready", o_lsu_ready, 1);
    @(negedge clk); #1 checkOutput("rw_req_in_req", bus_if.o_bus_req, 1);
    @(negedge clk); #1 checkOutput("rw_req_in_wait", bus_if.o_bus_req, 0);
    #2 rst_n = 0;
    #1;
    checkOutput("rw_req", bus_if.o_bus_req, 0);
    checkOutput("rw_done", o_lsu_done, 0);
    checkOutput("rw_err", o_lsu_err, 0);
    checkOutput("rw_rdata", o_lsu_rdata, 0);
    checkOutput("rw_wmask", bus_if.o_bus_wmask, 0);
    @(negedge clk); lsu_valid = 0; lsu_read = 0;
    @(negedge clk); rst_n = 1; stray_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1 checkOutput("stray_rvalid_done", o_lsu_done, 0);
    end

    $display("[TB] randomized accesses");
    for (int t = 0; t < 200; t++) begin
      op = $urandom_range(19);
      sz = 3'($urandom_range(7));
      n  = 1 << sz[1:0];
      a  = {$urandom, $urandom};
      if ($urandom_range(9) < 7) a = a & ~(64'(n) - 64'd1);
      applyStimulus(op == 0 ? 1'b1 : (op == 1 ? 1'b0 : op[0]),
                    op == 0 ? 1'b1 : (op == 1 ? 1'b0 : ~op[0]),
                    sz, a, {$urandom, $urandom},
                    $urandom_range(3), $urandom_range(3), {$urandom, $urandom},
                    $urandom_range(9) == 0, $urandom_range(9) == 0);
      if ($urandom_range(3) == 0) idleCycles($urandom_range(2));
    end
    idleCycles(1);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || plan_q.size() != 0); i++) @(negedge clk);
    checkOutput("queues_drained", exp_q.size() + plan_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
